// File: rtl/ysyx_22050133_ifq.sv
// Instruction fetch queue: issues in-order imem requests under a credit rule and buffers returned
// instructions for decode. Define YSYX_22050133_IFQ_BYPASS_EN to forward a response straight to the outputs when the queue is empty.
module ysyx_22050133_ifq #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          MAX_OUT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [PW-1:0] head_q, head_d;
  logic [63:0]   ent_pc_q   [DEPTH];
  logic [63:0]   ent_pc_d   [DEPTH];
  logic [31:0]   ent_inst_q [DEPTH];
  logic [31:0]   ent_inst_d [DEPTH];
  logic [63:0]   tag_q      [MAX_OUT];
  logic [63:0]   tag_d      [MAX_OUT];
  logic [2:0]    tag_cnt_q, tag_cnt_d;
  logic [2:0]    disc_q, disc_d;

  logic [3:0]    inflight;
  logic [5:0]    credit_sum;
  logic [PW-1:0] tail;
  logic [2:0]    post_cnt;
  logic          queue_empty;
  logic          req_fire;
  logic          rsp_take;
  logic          rsp_good;
  logic          rsp_disc;
  logic          bypass;
  logic          enq;
  logic          deq;

  // Inflight counts discarded responses too, so credit stays honest while draining.
  assign inflight    = {1'b0, tag_cnt_q} + {1'b0, disc_q};
  assign credit_sum  = 6'(occ_q) + 6'(inflight);
  assign queue_empty = (occ_q == '0);
  assign tail        = head_q + PW'(occ_q);

  assign imem_req_valid = rst && !redirect_valid && (credit_sum < 6'(DEPTH))
                          && (inflight < 4'(MAX_OUT));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_take = imem_rsp_valid && (inflight != 4'd0);
  assign rsp_good = rsp_take && (disc_q == 3'd0);
  assign rsp_disc = rsp_take && (disc_q != 3'd0);
  assign post_cnt = tag_cnt_q - {2'b0, rsp_good};

`ifdef YSYX_22050133_IFQ_BYPASS_EN
  assign bypass    = rsp_good && queue_empty && !redirect_valid;
  assign out_valid = rst && (!queue_empty || bypass);
  assign enq       = rsp_good && !redirect_valid && !(bypass && out_ready);
`else
  assign bypass    = 1'b0;
  assign out_valid = rst && !queue_empty;
  assign enq       = rsp_good && !redirect_valid;
`endif
  assign deq = rst && !queue_empty && out_ready && !redirect_valid;

  always_comb begin
    out_pc   = 64'd0;
    out_inst = 32'd0;
    if (out_valid) begin
      if (!queue_empty) begin
        out_pc   = ent_pc_q[head_q];
        out_inst = ent_inst_q[head_q];
      end else if (bypass) begin
        out_pc   = tag_q[0];
        out_inst = imem_rsp_inst;
      end
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    occ_d      = occ_q;
    head_d     = head_q;
    tag_cnt_d  = tag_cnt_q;
    disc_d     = disc_q;
    ent_pc_d   = ent_pc_q;
    ent_inst_d = ent_inst_q;
    tag_d      = tag_q;
    if (redirect_valid) begin
      // Everything still in flight becomes garbage, minus a response consumed this cycle.
      fetch_pc_d = redirect_pc;
      occ_d      = '0;
      head_d     = '0;
      tag_cnt_d  = 3'd0;
      disc_d     = 3'(inflight - 4'(rsp_take));
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 64'd4;
      if (rsp_disc) disc_d = disc_q - 3'd1;
      if (rsp_good) begin
        for (int i = 0; i < MAX_OUT - 1; i++) tag_d[i] = tag_q[i+1];
      end
      for (int i = 0; i < MAX_OUT; i++) begin
        if (req_fire && post_cnt == 3'(i)) tag_d[i] = fetch_pc_q;
      end
      tag_cnt_d = post_cnt + {2'b0, req_fire};
      for (int i = 0; i < DEPTH; i++) begin
        if (enq && tail == PW'(i)) begin
          ent_pc_d[i]   = tag_q[0];
          ent_inst_d[i] = imem_rsp_inst;
        end
      end
      occ_d = occ_q + CW'(enq) - CW'(deq);
      if (deq) head_d = head_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      occ_q      <= '0;
      head_q     <= '0;
      tag_cnt_q  <= 3'd0;
      disc_q     <= 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc_q[i]   <= 64'd0;
        ent_inst_q[i] <= 32'd0;
      end
      for (int i = 0; i < MAX_OUT; i++) tag_q[i] <= 64'd0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tag_cnt_q  <= tag_cnt_d;
      disc_q     <= disc_d;
      ent_pc_q   <= ent_pc_d;
      ent_inst_q <= ent_inst_d;
      tag_q      <= tag_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22050133_ifq.sv
// Bench for ysyx_22050133_ifq: in-order memory model plus a queue-level reference model
// checked every cycle, with directed scenarios pinning literal addresses.
module tb_ysyx_22050133_ifq;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_inst;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;

  ysyx_22050133_ifq #(.DEPTH(DEPTH), .RESET_PC(64'h8000_0000), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_inst(imem_rsp_inst), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // reference model: fetch pointer, queue contents, outstanding tags, discard count
  logic [63:0] m_fetch;
  logic [63:0] m_qpc[$];
  logic [31:0] m_qinst[$];
  logic [63:0] m_tags[$];
  int          m_disc;
  // memory: accepted addresses and the cycle they were accepted
  logic [63:0] mem_addr[$];
  int          mem_cyc[$];

  logic rsp_en, spur;
  logic s_req_valid, s_out_valid, s_fire, s_rsp_valid;
  logic [63:0] s_req_addr, s_out_pc, s_rsp_addr;

  function automatic logic [31:0] mk_inst(logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fetch = 64'h8000_0000;
    m_qpc.delete(); m_qinst.delete(); m_tags.delete();
    m_disc = 0;
    mem_addr.delete(); mem_cyc.delete();
  endtask

  task automatic step();
    logic e_req, take, good, byp, e_ov, fire, deq, from_mem;
    logic [63:0] e_pc, pc;
    logic [31:0] e_inst;
    int infl;
    from_mem = rsp_en && (mem_addr.size() > 0) && (mem_cyc[0] < cyc);
    if (from_mem) begin
      imem_rsp_valid = 1'b1; imem_rsp_inst = mk_inst(mem_addr[0]);
    end else if (spur && mem_addr.size() == 0) begin
      imem_rsp_valid = 1'b1; imem_rsp_inst = $urandom;
    end else begin
      imem_rsp_valid = 1'b0; imem_rsp_inst = $urandom;
    end
    s_rsp_valid = from_mem;
    s_rsp_addr  = from_mem ? mem_addr[0] : 64'd0;
    #1;
    infl  = m_tags.size() + m_disc;
    e_req = rst && !redirect_valid && (m_qpc.size() + infl < DEPTH) && (infl < MAX_OUT);
    take  = rst && imem_rsp_valid && (infl > 0);
    good  = take && (m_disc == 0);
    byp   = 1'b0;
`ifdef YSYX_22050133_IFQ_BYPASS_EN
    byp = good && (m_qpc.size() == 0) && !redirect_valid;
`endif
    e_ov = rst && ((m_qpc.size() > 0) || byp);
    e_pc = 64'd0; e_inst = 32'd0;
    if (e_ov && m_qpc.size() > 0) begin
      e_pc = m_qpc[0]; e_inst = m_qinst[0];
    end else if (e_ov) begin
      e_pc = m_tags[0]; e_inst = imem_rsp_inst;
    end
    s_req_valid = imem_req_valid; s_req_addr = imem_req_addr;
    s_out_valid = out_valid; s_out_pc = out_pc;
    s_fire = imem_req_valid && imem_req_ready;
    chk("req_valid", 64'(imem_req_valid), 64'(e_req));
    if (e_req) chk("req_addr", imem_req_addr, m_fetch);
    chk("out_valid", 64'(out_valid), 64'(e_ov));
    if (e_ov || !rst) begin
      chk("out_pc", out_pc, e_pc);
      chk("out_inst", 64'(out_inst), 64'(e_inst));
    end
    fire = e_req && imem_req_ready;
    deq  = rst && !redirect_valid && (m_qpc.size() > 0) && out_ready;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (from_mem) begin
        void'(mem_addr.pop_front()); void'(mem_cyc.pop_front());
      end
      if (redirect_valid) begin
        m_disc = infl - (take ? 1 : 0);
        m_tags.delete(); m_qpc.delete(); m_qinst.delete();
        m_fetch = redirect_pc;
      end else begin
        if (deq) begin
          void'(m_qpc.pop_front()); void'(m_qinst.pop_front());
        end
        if (take) begin
          if (m_disc > 0) m_disc--;
          else begin
            pc = m_tags.pop_front();
            if (!(byp && out_ready)) begin
              m_qpc.push_back(pc); m_qinst.push_back(imem_rsp_inst);
            end
          end
        end
        if (fire) begin
          m_tags.push_back(m_fetch);
          mem_addr.push_back(m_fetch); mem_cyc.push_back(cyc);
          m_fetch = m_fetch + 64'd4;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; redirect_valid = 1'b0; spur = 1'b0;
    step(); step();
    rst = 1'b1;
  endtask

  initial begin
    int n;
    logic seen;
    logic [63:0] first;
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_inst = 32'd0; out_ready = 1'b0;
    rsp_en = 1'b0; spur = 1'b0;
    model_reset();
    @(negedge clk);

    // streaming fetch with a one-cycle memory
    do_reset();
    imem_req_ready = 1'b1; rsp_en = 1'b1; out_ready = 1'b1;
    step();
    chk("stream_req0_valid", 64'(s_req_valid), 64'd1);
    chk("stream_req0_addr", s_req_addr, 64'h8000_0000);
    step();
    chk("stream_req1_addr", s_req_addr, 64'h8000_0004);
    step();
    chk("stream_ov_c2", 64'(s_out_valid), 64'd1);
`ifdef YSYX_22050133_IFQ_BYPASS_EN
    chk("stream_pc_c2", s_out_pc, 64'h8000_0004);
`else
    chk("stream_pc_c2", s_out_pc, 64'h8000_0000);
`endif
    repeat (8) step();

    // decode stalled: fill to DEPTH then stop requesting
    do_reset();
    imem_req_ready = 1'b1; rsp_en = 1'b1; out_ready = 1'b0;
    n = 0;
    repeat (20) begin
      step();
      if (s_fire) n++;
    end
    chk("fill_req_count", 64'(n), 64'd4);
    chk("fill_req_valid_low", 64'(s_req_valid), 64'd0);
    chk("fill_head_pc", s_out_pc, 64'h8000_0000);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    chk("fill_resume_valid", 64'(s_req_valid), 64'd1);
    chk("fill_resume_addr", s_req_addr, 64'h8000_0010);

    // redirect with two requests outstanding
    do_reset();
    imem_req_ready = 1'b1; rsp_en = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    chk("two_out_no_req", 64'(s_req_valid), 64'd0);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
    step();
    redirect_valid = 1'b0; rsp_en = 1'b1;
    step();
    chk("post_redirect_ov", 64'(s_out_valid), 64'd0);
    seen = 1'b0; first = 64'd0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_out_valid && !seen) begin seen = 1'b1; first = s_out_pc; end
    end
    chk("redirect_first_pc", first, 64'h8000_0100);

    // redirect coinciding with the response for 0x80000008
    do_reset();
    imem_req_ready = 1'b1; rsp_en = 1'b1; out_ready = 1'b0;
    step(); step(); step();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
    step();
    redirect_valid = 1'b0;
    step();
    chk("coinc_ov", 64'(s_out_valid), 64'd0);
    chk("coinc_req_valid", 64'(s_req_valid), 64'd1);
    chk("coinc_req_addr", s_req_addr, 64'h8000_0200);
    repeat (6) step();

    // latency of the response for 0x80000010
    do_reset();
    imem_req_ready = 1'b1; rsp_en = 1'b1; out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (!seen && s_rsp_valid && s_rsp_addr == 64'h8000_0010) begin
        seen = 1'b1;
`ifndef YSYX_22050133_IFQ_BYPASS_EN
        step();
`endif
        chk("lat_ov", 64'(s_out_valid), 64'd1);
        chk("lat_pc", s_out_pc, 64'h8000_0010);
      end
    end
    chk("lat_seen", 64'(seen), 64'd1);

    // reset with two requests in flight
    do_reset();
    imem_req_ready = 1'b1; rsp_en = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_req_valid", 64'(s_req_valid), 64'd0);
    chk("rst_ov", 64'(s_out_valid), 64'd0);
    chk("rst_pc_zero", s_out_pc, 64'd0);
    rst = 1'b1; rsp_en = 1'b1;
    step();
    chk("rst_first_req", s_req_addr, 64'h8000_0000);
    seen = 1'b0; first = 64'd0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_out_valid && !seen) begin seen = 1'b1; first = s_out_pc; end
    end
    chk("rst_first_out_pc", first, 64'h8000_0000);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst            = ($urandom_range(99) != 0);
      redirect_valid = ($urandom_range(19) == 0);
      if ($urandom_range(7) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF4;
      else redirect_pc = {$urandom, $urandom} & ~64'h3;
      imem_req_ready = ($urandom_range(9) < 7);
      rsp_en         = ($urandom_range(9) < 6);
      out_ready      = ($urandom_range(9) < 6);
      spur           = $urandom_range(1) == 1;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ysyx_22050133_ifq.md
YSYX_22050133_IFQ -- requirements
Module: ysyx_22050133_ifq

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 64'h8000_0000, meaning first fetch address after reset.
REQ-003 SHALL have parameter MAX_OUT, default 2, meaning maximum outstanding imem requests (1..4).
REQ-004 clk  in  1  sole clock, all state updates on posedge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 redirect_valid  in  1  flush and restart fetch (taken branch/jump from MEM stage).
REQ-007 redirect_pc  in  64  restart address.
REQ-008 imem_req_valid  out  1  fetch request valid.
REQ-009 imem_req_ready  in  1  memory accepts request.
REQ-010 imem_req_addr  out  64  fetch address.
REQ-011 imem_rsp_valid  in  1  instruction returned, in request order, at least 1 cycle after acceptance.
REQ-012 imem_rsp_inst  in  32  returned instruction.
REQ-013 out_valid  out  1  head entry valid toward IDREG.
REQ-014 out_ready  in  1  decode accepts head (low while hazard stall).
REQ-015 out_pc  out  64  PC of head entry.
REQ-016 out_inst  out  32  instruction of head entry.

Function
REQ-017 SHALL hold fetch_pc; imem_req_addr = fetch_pc; fetch_pc += 4 (mod 2^64) on each request handshake.
REQ-018 SHALL assert imem_req_valid only when occupancy + inflight < DEPTH, inflight < MAX_OUT, and redirect_valid low.
REQ-019 SHALL record the PC of each accepted request in an inflight tag FIFO of MAX_OUT entries; response pairs with oldest tag.
REQ-020 SHALL enqueue {tag_pc, imem_rsp_inst} on imem_rsp_valid when discard count is zero; queue never overflows by REQ-018 credit rule.
REQ-021 SHALL drive out_valid = queue non-empty; out_pc/out_inst = head entry; dequeue on out_valid & out_ready.
REQ-022 Simultaneous enqueue and dequeue SHALL keep occupancy unchanged, including when full or when count is 1.
REQ-023 Latency: request accepted cycle N, response cycle N+k, out_valid high cycle N+k+1 (REQ-033 overrides).
REQ-024 On redirect_valid: same cycle, queue cleared, no dequeue counted, no enqueue, fetch_pc <= redirect_pc, tag FIFO cleared.
REQ-025 On redirect: discard count <= inflight minus 1 if imem_rsp_valid that cycle, else inflight; discarded responses decrement it, never enqueued.
REQ-026 Request handshake and redirect SHALL NOT coincide (REQ-018); first post-redirect request issued cycle after redirect.
REQ-027 imem_rsp_valid with inflight == 0 SHALL be ignored, no state change.
REQ-028 Discard count SHALL saturate at 0; new requests allowed while discarding if credit rule holds (inflight includes discarded).
REQ-029 out_valid SHALL be low the cycle after redirect regardless of responses.

Reset
REQ-030 When rst low at posedge: fetch_pc = RESET_PC, queue empty, inflight = 0, discard = 0.
REQ-031 During reset imem_req_valid = 0, out_valid = 0, out_pc = 0, out_inst = 0; mid-transaction reset abandons outstanding responses without discard (memory reset together).
REQ-032 First imem_req_valid SHALL assert the first cycle after rst returns high.

Configuration
REQ-033 Macro YSYX_22050133_IFQ_BYPASS_EN defined: when queue empty and undiscarded response arrives, out_valid/out_pc/out_inst SHALL present it same cycle; if out_ready also high, not enqueued.
REQ-034 Macro undefined: no bypass, outputs driven only from queue storage (REQ-023 latency).

Verification
REQ-035 Reset release, imem_req_ready=1, 1-cycle memory, out_ready=1 -> requests 0x80000000, 0x80000004, ...; out_pc stream identical, out_valid by cycle 3.
REQ-036 out_ready=0 for 20 cycles, DEPTH=4 -> exactly 4 requests accepted, occupancy 4, imem_req_valid low until a dequeue.
REQ-037 Two requests outstanding (0x80000000, 0x80000004), redirect_pc=0x80000100 -> both responses dropped, next out_pc=0x80000100.
REQ-038 Redirect in same cycle as response to 0x80000008 -> response dropped, discard = remaining inflight, no stale out_valid.
REQ-039 BYPASS_EN defined, queue empty, response for 0x80000010 with out_ready=1 -> out_valid same cycle, occupancy stays 0; undefined -> out_valid next cycle.
REQ-040 rst low with 2 requests inflight -> fetch_pc 0x80000000, out_valid 0, post-reset responses paired with new tags only.
